// File: rtl/issue_queue_pkg.sv
// Shared types and helpers for the in-order issue queue.
// Each entry holds the renamed instruction fields plus a pre-computed exception flag.
package issue_queue_types;

  localparam int IQ_NUM_UNITS  = 8;
  localparam int IQ_READ_PORTS = 2;
  localparam int IQ_ID_W       = 3;
  localparam int IQ_PHYS_W     = 6;

  typedef struct packed {
    logic [31:0]                         pc;
    logic [31:0]                         instruction;
    logic [IQ_ID_W-1:0]                  id;
    logic [IQ_NUM_UNITS-1:0]             unit_needed;
    logic [IQ_READ_PORTS-1:0]            uses_rs;
    logic [IQ_READ_PORTS*IQ_PHYS_W-1:0]  phys_rs;
    logic                                uses_rd;
    logic [IQ_PHYS_W-1:0]                phys_rd;
    logic                                fetch_ok;
    logic                                exc;
  } iq_entry_t;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic int iq_ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/iq_entry_ram.sv
// Entry storage for the issue queue: one synchronous write port, one asynchronous read port.
// Data is not reset; validity is tracked by the occupancy counter in the top level.
module iq_entry_ram
  import issue_queue_types::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  iq_entry_t        wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output iq_entry_t        rd_data
);

  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: DEPTH-entry circular buffer, head-only issue to one unit,
// and a registered exception pulse raised from an excepting head entry.
module issue_queue
  import issue_queue_types::*;
#(
  parameter int DEPTH      = 4,
  parameter int NUM_UNITS  = IQ_NUM_UNITS,
  parameter int READ_PORTS = IQ_READ_PORTS,
  parameter int ID_W       = IQ_ID_W,
  parameter int PHYS_W     = IQ_PHYS_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  output logic                         dec_ready,
  input  logic [31:0]                  dec_pc,
  input  logic [31:0]                  dec_instruction,
  input  logic [ID_W-1:0]              dec_id,
  input  logic [NUM_UNITS-1:0]         dec_unit_needed,
  input  logic [READ_PORTS-1:0]        dec_uses_rs,
  input  logic [READ_PORTS*PHYS_W-1:0] dec_phys_rs,
  input  logic                         dec_uses_rd,
  input  logic [PHYS_W-1:0]            dec_phys_rd,
  input  logic                         dec_fetch_ok,
  input  logic [NUM_UNITS-1:0]         unit_ready,
  input  logic [READ_PORTS-1:0]        rs_inuse,
  input  logic                         issue_hold,
  input  logic                         flush,
  output logic                         head_valid,
  output logic [READ_PORTS*PHYS_W-1:0] head_phys_rs,
  output logic [NUM_UNITS-1:0]         issue_to,
  output logic                         issued,
  output logic [31:0]                  issue_pc,
  output logic [31:0]                  issue_instruction,
  output logic [ID_W-1:0]              issue_id,
  output logic                         issue_uses_rd,
  output logic [PHYS_W-1:0]            issue_phys_rd,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         exc_valid,
  output logic [31:0]                  exc_pc,
  output logic [31:0]                  exc_tval
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  iq_entry_t             wr_entry, head;
  logic                  push, pop, exc_set;
  logic [READ_PORTS-1:0] operand_ready;

  always_comb begin
    wr_entry             = '0;
    wr_entry.pc          = dec_pc;
    wr_entry.instruction = dec_instruction;
    wr_entry.id          = dec_id;
    wr_entry.unit_needed = dec_unit_needed;
    wr_entry.uses_rs     = dec_uses_rs;
    wr_entry.phys_rs     = dec_phys_rs;
    wr_entry.uses_rd     = dec_uses_rd;
    wr_entry.phys_rd     = dec_phys_rd;
    wr_entry.fetch_ok    = dec_fetch_ok;
    wr_entry.exc         = ~dec_fetch_ok | ~|dec_unit_needed;
  end

  iq_entry_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  assign head_valid    = (occupancy != '0);
  assign operand_ready = ~rs_inuse | ~head.uses_rs;

  always_comb begin
    issue_to = '0;
    if (head_valid & ~head.exc & (&operand_ready) & ~issue_hold & ~flush)
      issue_to = head.unit_needed & unit_ready;
  end

  assign issued    = |issue_to;
  assign pop       = issued;
  assign dec_ready = (occupancy < OCC_W'(DEPTH)) | issued;
  assign push      = dec_valid & dec_ready & ~flush;

  assign head_phys_rs      = head.phys_rs;
  assign issue_pc          = head.pc;
  assign issue_instruction = head.instruction;
  assign issue_id          = head.id;
  assign issue_uses_rd     = head.uses_rd;
  assign issue_phys_rd     = head.phys_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(iq_ptr_inc(int'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= PTR_W'(iq_ptr_inc(int'(rd_ptr), DEPTH));
      if (push & ~pop)      occupancy <= occupancy + OCC_W'(1);
      else if (pop & ~push) occupancy <= occupancy - OCC_W'(1);
    end
  end

  // The excepting head is never popped; ~exc_valid keeps the pulse to one cycle.
  assign exc_set = head_valid & head.exc & ~issue_hold & ~flush & ~exc_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_valid <= 1'b0;
      exc_pc    <= '0;
      exc_tval  <= '0;
    end else begin
      exc_valid <= exc_set;
      if (exc_set) begin
        exc_pc   <= head.pc;
        exc_tval <= head.fetch_ok ? head.instruction : head.pc;
      end
    end
  end

  a_unit_onehot: assert property (@(posedge clk) disable iff (!rst)
    dec_valid |-> $onehot0(dec_unit_needed));
  a_push_ready: assert property (@(posedge clk) disable iff (!rst)
    push |-> dec_ready);
  a_issue_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(issue_to));

endmodule
